fft32_out_reorder: RTL and testbench
====================================

Name: fft32_out_reorder

Overview:
- Final block of the 32-point SDF FFT pipeline; consumes the last stage's serial complex output stream, which is in bit-reversed frequency order.
- Writes each 32-sample frame into a ping-pong buffer at bit-reversed addresses and reads it back sequentially, emitting X[0]..X[31] in natural order.
- Produces frame-delimited output with start-of-frame and end-of-frame markers for downstream consumers.
- No arithmetic, no scaling, no backpressure.

Parameters:
- DW, 14, width of each real/imag component (matches the final stage output width).
- N, 32, points per frame (fixed; must equal 2**LOGN).
- LOGN, 5, address / counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_i  input  1  sample qualifier from the last FFT stage.
- data_in_r  input  DW signed  real part, bit-reversed order.
- data_in_i  input  DW signed  imaginary part, bit-reversed order.
- valid_o  output  1  output sample qualifier.
- data_out_r  output  DW signed  real part, natural order.
- data_out_i  output  DW signed  imaginary part, natural order.
- sop_o  output  1  high with X[0] of each frame.
- eop_o  output  1  high with X[31] of each frame.

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: valid_o=0, sop_o=0, eop_o=0, data_out_r=0, data_out_i=0. Reset also clears:
  - wr_cnt=0, rd_cnt=0;
  - wr_bank=0;
  - rd_active=0.
  - Buffer contents need not be cleared.
- Write side:
  - Each valid_i=1 edge writes {data_in_r, data_in_i} into bank wr_bank at address bitrev5(wr_cnt), then wr_cnt increments (mod 32).
  - Gaps (valid_i=0) hold wr_cnt; no write occurs.
- Frame completion (the edge writing wr_cnt==31):
  - wr_bank toggles.
  - rd_bank <= old wr_bank.
  - rd_cnt <= 0.
  - rd_active <= 1.
- Read side:
  - While rd_active, each edge registers bank rd_bank at address rd_cnt onto data_out_*, sets valid_o=1, then increments rd_cnt.
  - sop_o=1 when the registered address is 0. eop_o=1 when it is 31.
  - After address 31, rd_active clears unless a new frame completed on that same edge.
  - Idle outputs: valid_o=0, sop_o=0, eop_o=0; data_out_* hold their last value.
- Latency: the first output (X[0], valid_o=1) appears on the edge immediately after the edge that wrote input sample 31.
  - The 32 outputs are then emitted on 32 consecutive edges, regardless of input gaps.
- Back-to-back frames: input rate is at most 1 sample per cycle, so the next frame completes no earlier than the edge that emits X[31].
  - Simultaneous completion and last read: the new frame's X[0] follows on the next edge, so valid_o stays continuously high with no bubble.
  - The writer never overwrites a bank still being read; no overflow condition exists.
- Data: bit-exact pass-through, no rounding and no sign handling beyond storage.
- Reset mid-operation: any partial input frame and any in-progress output frame are discarded. Outputs go to reset values immediately (asynchronous).
- Reset sequencing: the first valid_i after reset is treated as sample 0 of a new frame.

Decomposition:
- Package fft32_pkg:
  - FFT_N=32, FFT_LOGN=5, FFT_OUT_DW=14;
  - function bitrev5 (reverses a 5-bit index);
  - complex sample typedef {signed [DW-1:0] r, i}.
- Sub-module fft32_pingpong_mem: 2 banks x 32 words x 2*DW flops.
  - One synchronous write port and one asynchronous read port.
  - Bank select plus 5-bit address on each port.
- The control counters and bank pointers stay in fft32_out_reorder.

Test Plan:
- Ramp frame: drive 32 consecutive valid samples with data_in_r=n, data_in_i=-n.
  - Output k must be r=bitrev5(k), i=-bitrev5(k), i.e. r = 0,16,8,24,4,20,...,31.
  - First valid_o on the edge after input 31; sop_o with k=0, eop_o with k=31.
- Gapped input: valid_i asserted every 3rd cycle for one frame.
  - Same output values as the ramp frame.
  - Outputs are 32 consecutive valid cycles starting one edge after the last input.
- Back-to-back: 4 frames streamed continuously (128 cycles, valid_i=1).
  - valid_o must be high for 128 consecutive cycles with no bubbles.
  - sop_o must occur at cycles 0, 32, 64 and 96 of the output run.
  - Every frame must be correctly reordered.
- Reset mid-frame: after 10 input samples, pulse rst for 1 cycle.
  - valid_o drops immediately.
  - Then a full ramp frame is driven; the output matches the ramp expectation, with no residue from the aborted frame.
- Reset mid-output: assert rst while output k=12 is being emitted.
  - valid_o, sop_o and eop_o are 0 immediately; no further outputs appear until a new full frame has been input.
- Extreme values: frame alternating +8191/-8192 in both components.
  - Exact values must be reproduced at the reordered positions, with no sign corruption.

Source files
------------

// File: rtl/fft32_pkg.sv
// Shared constants, types and index helpers for the 32-point FFT output stage.
package fft32_pkg;

    localparam int FFT_N      = 32;
    localparam int FFT_LOGN   = 5;
    localparam int FFT_OUT_DW = 14;

    typedef struct packed {
        logic signed [FFT_OUT_DW-1:0] r;
        logic signed [FFT_OUT_DW-1:0] i;
    } cplx_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_ACTIVE = 1'b1
    } rd_state_t;

    function automatic logic [FFT_LOGN-1:0] bitrev5(input logic [FFT_LOGN-1:0] idx);
        logic [FFT_LOGN-1:0] rev;
        rev = '0;
        for (int unsigned b = 0; b < FFT_LOGN; b++) begin
            rev[b] = idx[FFT_LOGN-1-b];
        end
        return rev;
    endfunction

endpackage

// File: rtl/fft32_pingpong_mem.sv
// Two-bank frame buffer: one synchronous write port, one asynchronous read port.
module fft32_pingpong_mem #(
    parameter int DW   = 14,
    parameter int LOGN = 5
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              wr_bank_i,
    input  logic [LOGN-1:0]   wr_addr_i,
    input  logic [2*DW-1:0]   wr_data_i,
    input  logic              rd_bank_i,
    input  logic [LOGN-1:0]   rd_addr_i,
    output logic [2*DW-1:0]   rd_data_o
);

    localparam int NW = 2**LOGN;

    logic [2*DW-1:0] mem_q [2][NW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_bank_i][rd_addr_i];

endmodule

// File: rtl/fft32_out_reorder.sv
// Reorders bit-reversed FFT output frames into natural order via a ping-pong buffer,
// emitting each frame as 32 consecutive samples with start/end-of-frame markers.
module fft32_out_reorder
    import fft32_pkg::*;
#(
    parameter int DW   = FFT_OUT_DW,
    parameter int N    = FFT_N,
    parameter int LOGN = FFT_LOGN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic signed [DW-1:0] data_in_r,
    input  logic signed [DW-1:0] data_in_i,
    output logic                 valid_o,
    output logic signed [DW-1:0] data_out_r,
    output logic signed [DW-1:0] data_out_i,
    output logic                 sop_o,
    output logic                 eop_o
);

    localparam logic [LOGN-1:0] LAST = LOGN'(N-1);

    logic [LOGN-1:0]   wr_cnt_q, wr_cnt_d;
    logic [LOGN-1:0]   rd_cnt_q, rd_cnt_d;
    logic              wr_bank_q, rd_bank_q;
    rd_state_t         rd_state_q;
    logic              frame_done;
    logic [2*DW-1:0]   rd_word;
    logic              valid_q, sop_q, eop_q;
    logic signed [DW-1:0] dout_r_q, dout_i_q;

    always_comb begin
        wr_cnt_d   = wr_cnt_q + LOGN'(1);
        rd_cnt_d   = rd_cnt_q + LOGN'(1);
        frame_done = valid_i && (wr_cnt_q == LAST);
    end

    fft32_pingpong_mem #(
        .DW   (DW),
        .LOGN (LOGN)
    ) u_mem (
        .clk       (clk),
        .we_i      (valid_i),
        .wr_bank_i (wr_bank_q),
        .wr_addr_i (bitrev5(wr_cnt_q)),
        .wr_data_i ({data_in_r, data_in_i}),
        .rd_bank_i (rd_bank_q),
        .rd_addr_i (rd_cnt_q),
        .rd_data_o (rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_state_q <= RD_IDLE;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            dout_r_q   <= '0;
            dout_i_q   <= '0;
        end else begin
            if (valid_i) begin
                wr_cnt_q <= wr_cnt_d;
            end

            if (rd_state_q == RD_ACTIVE) begin
                dout_r_q <= rd_word[2*DW-1:DW];
                dout_i_q <= rd_word[DW-1:0];
                valid_q  <= 1'b1;
                sop_q    <= (rd_cnt_q == '0);
                eop_q    <= (rd_cnt_q == LAST);
                rd_cnt_q <= rd_cnt_d;
                if (rd_cnt_q == LAST) begin
                    rd_state_q <= RD_IDLE;
                end
            end else begin
                valid_q <= 1'b0;
                sop_q   <= 1'b0;
                eop_q   <= 1'b0;
            end

            // A completing frame overrides the end-of-read idle so back-to-back frames stream without a bubble.
            if (frame_done) begin
                wr_bank_q  <= ~wr_bank_q;
                rd_bank_q  <= wr_bank_q;
                rd_cnt_q   <= '0;
                rd_state_q <= RD_ACTIVE;
            end
        end
    end

    assign valid_o    = valid_q;
    assign sop_o      = sop_q;
    assign eop_o      = eop_q;
    assign data_out_r = dout_r_q;
    assign data_out_i = dout_i_q;

endmodule

// File: tb/tb_fft32_out_reorder.sv
// Randomized scoreboard bench for fft32_out_reorder against a frame-level reorder model.
module tb_fft32_out_reorder;
    import fft32_pkg::*;

    localparam int DW = FFT_OUT_DW;

    logic                 clk;
    logic                 rst;
    logic                 valid_i;
    logic signed [DW-1:0] data_in_r;
    logic signed [DW-1:0] data_in_i;
    logic                 valid_o;
    logic signed [DW-1:0] data_out_r;
    logic signed [DW-1:0] data_out_i;
    logic                 sop_o;
    logic                 eop_o;

    fft32_out_reorder #(
        .DW   (DW),
        .N    (FFT_N),
        .LOGN (FFT_LOGN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .data_in_r  (data_in_r),
        .data_in_i  (data_in_i),
        .valid_o    (valid_o),
        .data_out_r (data_out_r),
        .data_out_i (data_out_i),
        .sop_o      (sop_o),
        .eop_o      (eop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        cplx_t d;
        logic  sop;
        logic  eop;
        int    cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     total = 0;
    int     bad   = 0;
    int     cyc   = 0;
    cplx_t  frm [32];
    int     fcnt  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rev_idx(input int k);
        int r = 0;
        for (int b = 0; b < 5; b++) r = r * 2 + ((k >> b) % 2);
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Output k of a frame is input sample rev_idx(k); it leaves 1+k edges after the edge taking sample 31.
    task automatic drive(input logic signed [DW-1:0] r, input logic signed [DW-1:0] im);
        exp_t e;
        @(negedge clk);
        valid_i   = 1'b1;
        data_in_r = r;
        data_in_i = im;
        frm[fcnt].r = r;
        frm[fcnt].i = im;
        fcnt++;
        if (fcnt == 32) begin
            for (int k = 0; k < 32; k++) begin
                e.d   = frm[rev_idx(k)];
                e.sop = (k == 0);
                e.eop = (k == 31);
                e.cyc = cyc + 2 + k;
                exp_q.push_back(e);
            end
            fcnt = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
    endtask

    task automatic do_reset(input bit wait_edge);
        if (wait_edge) @(negedge clk);
        #2;
        rst     = 1'b1;
        valid_i = 1'b0;
        exp_q.delete();
        fcnt = 0;
        #1;
        chk("rst_valid_o", int'(valid_o), 0);
        chk("rst_sop_o",   int'(sop_o),   0);
        chk("rst_eop_o",   int'(eop_o),   0);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic ramp_frame(input int gap);
        for (int n = 0; n < 32; n++) begin
            drive(DW'(n), DW'(-n));
            if (gap > 0 && n != 31) idle(gap);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_output: got valid_o=0 expected output due at cycle %0d (now %0d)",
                         exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got valid_o=1 r=%0d i=%0d expected no output (cycle %0d)",
                             data_out_r, data_out_i, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_cycle", cyc, e.cyc);
                    chk("out_r",     int'(data_out_r), int'(e.d.r));
                    chk("out_i",     int'(data_out_i), int'(e.d.i));
                    chk("out_sop",   int'(sop_o), int'(e.sop));
                    chk("out_eop",   int'(eop_o), int'(e.eop));
                end
            end else if (sop_o || eop_o) begin
                total++;
                bad++;
                $display("FAIL idle_markers: got sop_o=%0b eop_o=%0b expected 0 0 (cycle %0d)",
                         sop_o, eop_o, cyc);
            end
        end
    end

    initial begin
        int tgt;
        int waited;
        rst       = 1'b1;
        valid_i   = 1'b0;
        data_in_r = '0;
        data_in_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid_o", int'(valid_o), 0);
        chk("reset_sop_o",   int'(sop_o),   0);
        chk("reset_eop_o",   int'(eop_o),   0);
        chk("reset_out_r",   int'(data_out_r), 0);
        chk("reset_out_i",   int'(data_out_i), 0);
        #2 rst = 1'b0;

        ramp_frame(0);
        idle(40);

        ramp_frame(2);
        idle(40);

        for (int f = 0; f < 4; f++) begin
            for (int n = 0; n < 32; n++) drive(DW'($urandom), DW'($urandom));
        end
        // Abort a partial frame while the last streamed frame is still being emitted.
        for (int n = 0; n < 10; n++) drive(DW'($urandom), DW'($urandom));
        do_reset(1'b1);
        idle(5);
        ramp_frame(0);
        idle(40);

        ramp_frame(0);
        tgt = cyc + 1 + 13;
        while (cyc < tgt) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
        do_reset(1'b0);
        idle(50);

        for (int n = 0; n < 32; n++) begin
            if (n % 2 == 0) drive(DW'(8191), DW'(-8192));
            else            drive(DW'(-8192), DW'(8191));
        end
        idle(40);

        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 32; n++) begin
                drive(DW'($urandom), DW'($urandom));
                idle($urandom_range(0, 2));
            end
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 200) begin
            @(negedge clk);
            valid_i = 1'b0;
            waited++;
        end
        idle(2);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
